mem_stream_reader: RTL and testbench

MEM_STREAM_READER -- requirements
Module: mem_stream_reader

---
 rtl/mem_stream_pkg.sv | 15 +
 rtl/mem_stream_fifo.sv | 58 +++++
 rtl/mem_stream_reader.sv | 128 ++++++++++++
 tb/tb_mem_stream_reader.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stream_pkg.sv
// rtl/mem_stream_pkg.sv - shared state encoding and default sizing for the memory stream reader
package mem_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int DEF_ADDR_W     = 15;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_MEM_WORDS  = 17920;
    localparam int DEF_FIFO_DEPTH = 4;

endpackage

// File: rtl/mem_stream_fifo.sv
// rtl/mem_stream_fifo.sv - synchronous FIFO buffering RAM read data ahead of the stream port
module mem_stream_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              empty,
    output logic              full,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign do_pop   = pop && !empty;
    // A push into a full FIFO is legal only when a pop frees the slot in the same cycle.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_stream_reader.sv
// rtl/mem_stream_reader.sv - reads a block of words from on-chip RAM and streams them out
module mem_stream_reader
    import mem_stream_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int MEM_WORDS  = DEF_MEM_WORDS,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [15:0]       word_count,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] address,
    output logic              chipselect,
    output logic              write,
    output logic [3:0]        byteenable,
    output logic              clken,
    output logic [DATA_W-1:0] writedata,
    input  logic [DATA_W-1:0] readdata,
    output logic [DATA_W-1:0] st_data,
    output logic              st_valid,
    input  logic              st_ready
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W:0]    DEPTH_L   = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_WORDS - 1);

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       reads_left_q;
    logic              inflight_q;
    logic              done_zero_q;
    logic              issue;
    logic              drain_done;
    logic              accept;
    logic              pop;
    logic              fifo_empty;
    logic              fifo_full;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W:0]    occupancy;

    assign accept    = (state_q == ST_IDLE) && start;
    // Reserve a slot for every read still in flight so a landing word always fits.
    assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};

    always_comb begin
        state_d    = state_q;
        issue      = 1'b0;
        drain_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && (word_count != 16'd0)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if ((occupancy < DEPTH_L) && !fifo_full) begin
                    issue = 1'b1;
                    if (reads_left_q == 16'd1) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (fifo_empty && !inflight_q) begin
                    drain_done = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            reads_left_q <= '0;
            inflight_q   <= 1'b0;
            done_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            inflight_q  <= issue;
            done_zero_q <= accept && (word_count == 16'd0);
            if (accept) begin
                addr_q       <= base_addr;
                reads_left_q <= word_count;
            end else if (issue) begin
                addr_q       <= (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
                reads_left_q <= reads_left_q - 16'd1;
            end
        end
    end

    assign pop = st_valid && st_ready;

    mem_stream_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight_q),
        .push_data (readdata),
        .pop       (pop),
        .pop_data  (st_data),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    assign st_valid   = !fifo_empty;
    assign busy       = (state_q != ST_IDLE);
    assign done       = done_zero_q || drain_done;
    assign address    = addr_q;
    assign chipselect = issue;
    assign write      = 1'b0;
    assign writedata  = '0;
    assign byteenable = 4'hF;
    assign clken      = 1'b1;

endmodule

// File: tb/tb_mem_stream_reader.sv
// tb/tb_mem_stream_reader.sv - randomized self-checking bench against a block-read reference model
module tb_mem_stream_reader;

    localparam int ADDR_W     = 15;
    localparam int DATA_W     = 32;
    localparam int MEM_WORDS  = 17920;
    localparam int FIFO_DEPTH = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [15:0]       word_count = '0;
    logic              busy, done, chipselect, write, clken, st_valid;
    logic [ADDR_W-1:0] address;
    logic [3:0]        byteenable;
    logic [DATA_W-1:0] writedata, st_data;
    logic [DATA_W-1:0] readdata = '0;
    logic              st_ready = 1'b1;
    logic              ready_rnd = 1'b0;

    logic [DATA_W-1:0] mem [MEM_WORDS];
    int                cyc = 0;
    int                total = 0;
    int                bad = 0;

    logic [DATA_W-1:0] beat_q[$];
    int                beat_cyc_q[$];
    int                addr_q[$];
    int                occ_q[$];
    int                done_cyc_q[$];
    logic [DATA_W-1:0] stall_prev_q[$];
    logic [DATA_W-1:0] stall_cur_q[$];
    logic              stall_valid_q[$];

    mem_stream_reader #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .MEM_WORDS  (MEM_WORDS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .busy       (busy),
        .done       (done),
        .address    (address),
        .chipselect (chipselect),
        .write      (write),
        .byteenable (byteenable),
        .clken      (clken),
        .writedata  (writedata),
        .readdata   (readdata),
        .st_data    (st_data),
        .st_valid   (st_valid),
        .st_ready   (st_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Single-port RAM with one cycle of read latency
    always @(posedge clk) begin
        if (chipselect) readdata <= mem[address];
    end

    always @(posedge clk) begin
        #1;
        st_ready = ready_rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
    end

    // Passive monitor: records events only, all judging happens in the main sequence
    int          issued_n = 0;
    int          popped_n = 0;
    logic        prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data = '0;
    always @(negedge clk) begin
        if (reset) begin
            issued_n   = 0;
            popped_n   = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                stall_prev_q.push_back(prev_data);
                stall_cur_q.push_back(st_data);
                stall_valid_q.push_back(st_valid);
            end
            if (chipselect) begin
                addr_q.push_back(int'(address));
                occ_q.push_back(issued_n - popped_n);
                issued_n++;
            end
            if (st_valid && st_ready) begin
                beat_q.push_back(st_data);
                beat_cyc_q.push_back(cyc);
                popped_n++;
            end
            if (done) done_cyc_q.push_back(cyc);
            prev_stall = st_valid && !st_ready;
            prev_data  = st_data;
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int wrap_addr(input int a);
        return a % MEM_WORDS;
    endfunction

    task automatic do_xfer(input int base, input int cnt, input bit rnd, input bit extra_start);
        int b0, a0, d0, o0, s0, s, waited;
        b0 = beat_q.size();
        a0 = addr_q.size();
        d0 = done_cyc_q.size();
        o0 = occ_q.size();
        s0 = stall_cur_q.size();
        ready_rnd  = rnd;
        base_addr  = ADDR_W'(base);
        word_count = 16'(cnt);
        start      = 1'b1;
        s          = cyc;
        step();
        start = 1'b0;
        if (extra_start) begin
            repeat (3) step();
            base_addr  = ADDR_W'(wrap_addr(base + 1000));
            word_count = 16'd2;
            start      = 1'b1;
            step();
            start = 1'b0;
        end
        waited = 0;
        while (done_cyc_q.size() == d0 && waited < 3000) begin
            step();
            waited++;
        end
        check_val("done_within_bound", 64'(done_cyc_q.size() > d0), 64'd1);
        repeat (5) step();
        ready_rnd = 1'b0;
        check_val("done_pulses", 64'(done_cyc_q.size() - d0), 64'd1);
        check_val("beat_count", 64'(beat_q.size() - b0), 64'(cnt));
        check_val("read_count", 64'(addr_q.size() - a0), 64'(cnt));
        for (int i = 0; i < cnt; i++) begin
            if (b0 + i < beat_q.size())
                check_val("beat_data", 64'(beat_q[b0 + i]), 64'(mem[wrap_addr(base + i)]));
            if (a0 + i < addr_q.size())
                check_val("read_addr", 64'(addr_q[a0 + i]), 64'(wrap_addr(base + i)));
        end
        for (int i = o0; i < occ_q.size(); i++)
            check_val("room_at_issue", 64'(occ_q[i] < FIFO_DEPTH), 64'd1);
        for (int i = s0; i < stall_cur_q.size(); i++) begin
            check_val("stall_valid_held", 64'(stall_valid_q[i]), 64'd1);
            check_val("stall_data_held", 64'(stall_cur_q[i]), 64'(stall_prev_q[i]));
        end
        if (beat_q.size() - b0 == cnt && done_cyc_q.size() > d0) begin
            check_val("done_after_last_beat", 64'(done_cyc_q[d0]), 64'(beat_cyc_q[b0 + cnt - 1] + 1));
            if (!rnd) begin
                check_val("first_beat_latency", 64'(beat_cyc_q[b0] - s), 64'd3);
                check_val("back_to_back", 64'(beat_cyc_q[b0 + cnt - 1] - beat_cyc_q[b0]), 64'(cnt - 1));
            end
        end
        check_val("idle_after", 64'(busy), 64'd0);
    endtask

    initial begin
        int b0, d0, waited;
        for (int n = 0; n < MEM_WORDS; n++) mem[n] = DATA_W'(n);

        repeat (2) step();
        @(negedge clk);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_done", 64'(done), 64'd0);
        check_val("rst_cs", 64'(chipselect), 64'd0);
        check_val("rst_addr", 64'(address), 64'd0);
        check_val("rst_valid", 64'(st_valid), 64'd0);
        check_val("const_write", 64'(write), 64'd0);
        check_val("const_be", 64'(byteenable), 64'hF);
        check_val("const_clken", 64'(clken), 64'd1);
        check_val("const_wdata", 64'(writedata), 64'd0);
        step();
        reset = 1'b0;
        step();

        do_xfer(16'h10, 8, 1'b0, 1'b0);

        // Zero-length request completes without touching the RAM
        word_count = 16'd0;
        base_addr  = ADDR_W'(5);
        start      = 1'b1;
        step();
        start = 1'b0;
        @(negedge clk);
        check_val("zero_done", 64'(done), 64'd1);
        check_val("zero_busy", 64'(busy), 64'd0);
        check_val("zero_cs", 64'(chipselect), 64'd0);
        step();
        @(negedge clk);
        check_val("zero_done_once", 64'(done), 64'd0);
        check_val("zero_busy_after", 64'(busy), 64'd0);
        step();

        do_xfer(17918, 4, 1'b0, 1'b0);
        do_xfer(300, 16, 1'b1, 1'b0);
        do_xfer(40, 6, 1'b0, 1'b1);

        // Reset in the middle of a transfer
        b0 = beat_q.size();
        base_addr  = ADDR_W'(200);
        word_count = 16'd16;
        start      = 1'b1;
        step();
        start  = 1'b0;
        waited = 0;
        while (beat_q.size() - b0 < 3 && waited < 100) begin
            step();
            waited++;
        end
        check_val("three_beats_seen", 64'(beat_q.size() - b0 >= 3), 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        d0 = done_cyc_q.size();
        @(negedge clk);
        check_val("abort_busy", 64'(busy), 64'd0);
        check_val("abort_done", 64'(done), 64'd0);
        check_val("abort_cs", 64'(chipselect), 64'd0);
        check_val("abort_addr", 64'(address), 64'd0);
        check_val("abort_valid", 64'(st_valid), 64'd0);
        repeat (6) step();
        check_val("abort_no_done", 64'(done_cyc_q.size() - d0), 64'd0);
        do_xfer(500, 5, 1'b0, 1'b0);

        for (int t = 0; t < 5; t++)
            do_xfer($urandom_range(0, MEM_WORDS - 1), $urandom_range(1, 24), 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
